ccff_bitstream_loader: RTL and testbench

- Sits directly upstream of the routing-tile configuration chain and drives the chain's ccff_head input.
- Accepts bitstream words from the configuration host over a valid/ready interface and serialises them LSB-first, one bit per prog_clk cycle.
- Provides ccff_shift_en for the clock gate that feeds prog_clk into the chain.
- Counts bits up to the chain length, then signals completion.

---
 rtl/ccff_bitstream_loader.sv | 172 +++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Purpose  : Serialises host bitstream words LSB-first into the head of the
//            routing-tile configuration chain, one bit per prog_clk cycle,
//            and stops after exactly CHAIN_LEN bits.
// Ports    : prog_clk, prog_reset_n   - clock, async active-low reset
//            start                    - pulse; begins a load from IDLE/DONE
//            word_valid/word_data     - host word, bit 0 shifted first
//            word_ready               - word accepted this cycle (state decode)
//            ccff_head, ccff_shift_en - serial bit and chain clock enable
//            busy, done, bit_count    - load status / bits shifted so far
//            crc_out                  - CRC-16-CCITT of the shifted bits
//                                       (only with CCFF_LOADER_CRC_EN)
// Options  : define CCFF_LOADER_CRC_EN to add the crc_out port and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 10,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_LOADER_CRC_EN
    ,
    output logic [15:0]       crc_out
`endif
);

    localparam int              c_rem_w     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] c_chain_len = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORD_W-1:0]    r_sreg;
    logic [WORD_W-1:0]    w_sreg_nxt;
    // Bits of the current word still to be presented after the one on ccff_head.
    logic [c_rem_w-1:0]   r_remaining;
    logic [c_rem_w-1:0]   w_remaining_nxt;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 r_head;
    logic                 w_head_nxt;
    logic                 r_shift_en;
    logic                 w_shift_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic [31:0]          w_left;
    logic [31:0]          w_take;

    // Bits this word contributes: a full word, or only what the chain still
    // needs when the last word is partial (upper bits are simply dropped).
    assign w_left = 32'(CHAIN_LEN) - 32'(r_count);
    assign w_take = (w_left > 32'(WORD_W)) ? 32'(WORD_W) : w_left;

    // The registered outputs are loaded with the values for the state being
    // entered, so ccff_shift_en is high exactly during SHIFT cycles and the
    // first bit appears the cycle after the word is accepted.
    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_remaining_nxt = r_remaining;
        w_count_nxt     = r_count;
        w_head_nxt      = r_head;
        w_shift_nxt     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_count_nxt = '0;
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    w_state_nxt     = S_SHIFT;
                    w_head_nxt      = word_data[0];
                    w_shift_nxt     = 1'b1;
                    w_sreg_nxt      = word_data >> 1;
                    w_remaining_nxt = c_rem_w'(w_take - 32'd1);
                    w_count_nxt     = r_count + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (r_count == c_chain_len) begin
                    w_state_nxt = S_DONE;
                end else if (r_remaining == '0) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_head_nxt      = r_sreg[0];
                    w_shift_nxt     = 1'b1;
                    w_sreg_nxt      = r_sreg >> 1;
                    w_remaining_nxt = r_remaining - c_rem_w'(1);
                    w_count_nxt     = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_remaining <= w_remaining_nxt;
            r_count     <= w_count_nxt;
            r_head      <= w_head_nxt;
            r_shift_en  <= w_shift_nxt;
            r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign word_ready    = (r_state == S_LOAD);
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign bit_count     = r_count;

`ifdef CCFF_LOADER_CRC_EN
    // CRC-16-CCITT, MSB-first, fed with the bit the chain captures in each
    // enabled cycle; cleared whenever a new load is started.
    logic [15:0] r_crc;
    logic        w_crc_fb;
    logic        w_start_accept;

    assign w_crc_fb       = r_crc[15] ^ r_head;
    assign w_start_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_crc <= 16'hFFFF;
        end else if (w_start_accept) begin
            r_crc <= 16'hFFFF;
        end else if (r_shift_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign crc_out = r_crc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_bitstream_loader
// Purpose  : Self-checking bench for ccff_bitstream_loader. Instance 0 uses a
//            10-bit chain, instance 1 a 40-bit chain (two words, partial
//            last word). Expected chain contents are derived from the word
//            list: chain bit k = word[k/32] bit (k%32), for k < CHAIN_LEN.
//            Define CCFF_LOADER_CRC_EN to also check crc_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    logic        prog_clk = 1'b0;
    logic [1:0]  rst_n    = 2'b00;
    logic [1:0]  start    = 2'b00;
    logic [1:0]  valid    = 2'b00;
    logic [31:0] wdata [2];
    logic [1:0]  ready, head, se, busy, done;
    logic [3:0]  bc0;
    logic [5:0]  bc1;
`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc0, crc1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Per-load observations filled by drive_load
    logic [31:0] words_q[$];
    int          gaps_q[$];
    logic        obs_q[$];
    int          n_ready, n_idle_busy, n_rise, gap_err, mono_err, cnt_err;
    logic        first_done, first_busy, timed_out;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(10)) u_dut0 (
`ifdef CCFF_LOADER_CRC_EN
        .crc_out       (crc0),
`endif
        .prog_clk      (prog_clk),
        .prog_reset_n  (rst_n[0]),
        .start         (start[0]),
        .word_valid    (valid[0]),
        .word_data     (wdata[0]),
        .word_ready    (ready[0]),
        .ccff_head     (head[0]),
        .ccff_shift_en (se[0]),
        .busy          (busy[0]),
        .done          (done[0]),
        .bit_count     (bc0)
    );

    ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut1 (
`ifdef CCFF_LOADER_CRC_EN
        .crc_out       (crc1),
`endif
        .prog_clk      (prog_clk),
        .prog_reset_n  (rst_n[1]),
        .start         (start[1]),
        .word_valid    (valid[1]),
        .word_data     (wdata[1]),
        .word_ready    (ready[1]),
        .ccff_head     (head[1]),
        .ccff_shift_en (se[1]),
        .busy          (busy[1]),
        .done          (done[1]),
        .bit_count     (bc1)
    );

    // Reference model: chain contents expected from the current word list.
    function automatic logic [63:0] model_bits(input int len);
        logic [63:0] v;
        logic [31:0] wv;
        v = '0;
        for (int k = 0; k < len; k++) begin
            wv   = words_q[k / 32];
            v[k] = wv[k % 32];
        end
        return v;
    endfunction

    // Reference CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the first len bits.
    function automatic logic [15:0] model_crc(input logic [63:0] bits, input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < len; k++)
            c = (c << 1) ^ ((c[15] ^ bits[k]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    function automatic logic [63:0] pack_obs();
        logic [63:0] v;
        v = '0;
        foreach (obs_q[k]) if (k < 64) v[k] = obs_q[k];
        return v;
    endfunction

    // Pulses start on instance w, then plays words_q (waiting gaps_q[i] LOAD
    // cycles before offering word i) until done, stop_after shifts, or a
    // cycle budget expires. start is pulsed again when the shift counter
    // equals start_a or start_b. Called and returns at a negedge.
    task automatic drive_load(input int w, input int start_a, input int start_b,
                              input int stop_after);
        int   idx = 0;
        int   gap_left;
        int   cyc = 0;
        int   s_bc, prev_bc = 0;
        logic s_se, s_head, s_ready, s_busy, s_done;
        logic prev_se = 1'b0, prev_busy = 1'b0, prev_head;
        obs_q.delete();
        n_ready = 0; n_idle_busy = 0; n_rise = 0;
        gap_err = 0; mono_err = 0; cnt_err = 0; timed_out = 1'b0;
        gap_left  = (gaps_q.size() > 0) ? gaps_q[0] : 0;
        prev_head = head[w];
        start[w]  = 1'b1;
        valid[w]  = 1'b0;
        while (1) begin
            @(negedge prog_clk);
            start[w] = 1'b0;
            valid[w] = 1'b0;
            cyc++;
            s_se = se[w]; s_head = head[w]; s_ready = ready[w];
            s_busy = busy[w]; s_done = done[w];
            s_bc = (w == 0) ? int'(bc0) : int'(bc1);
            if (cyc == 1) begin
                first_done = s_done;
                first_busy = s_busy;
            end
            if (s_se) begin
                obs_q.push_back(s_head);
                if (!prev_se) n_rise++;
            end else if (s_busy && (s_head !== prev_head)) begin
                gap_err++;
            end
            if (s_busy && !s_se) n_idle_busy++;
            if (s_ready) n_ready++;
            if (s_busy && prev_busy && (s_bc < prev_bc)) mono_err++;
            if (s_bc != obs_q.size()) cnt_err++;
            prev_se = s_se; prev_head = s_head; prev_busy = s_busy; prev_bc = s_bc;
            if (s_done || (stop_after > 0 && obs_q.size() == stop_after)) break;
            if (cyc > 300) begin
                timed_out = 1'b1;
                break;
            end
            if (s_se && (obs_q.size() == start_a || obs_q.size() == start_b))
                start[w] = 1'b1;
            if (s_ready && idx < words_q.size()) begin
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    valid[w] = 1'b1;
                    wdata[w] = words_q[idx];
                    idx++;
                    gap_left = (idx < gaps_q.size()) ? gaps_q[idx] : 0;
                end
            end
        end
        start[w] = 1'b0;
        valid[w] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 2'b00;
        repeat (3) @(negedge prog_clk);
        n_cmp++;
        if ({ready, head, se, busy, done} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {ready, head, se, busy, done});
        end
        n_cmp++;
        if (bc0 !== 4'd0 || bc1 !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_bit_count: got %0d/%0d want 0/0", bc0, bc1);
        end
`ifdef CCFF_LOADER_CRC_EN
        n_cmp++;
        if (crc0 !== 16'hFFFF || crc1 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL reset_crc: got %h/%h want ffff", crc0, crc1);
        end
`endif
        rst_n = 2'b11;
        repeat (2) @(negedge prog_clk);
        n_cmp++;
        if ({ready, busy, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL idle_no_start: got %b want 0", {ready, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp_v;
        words_q = '{32'h0000_02B5};
        gaps_q  = '{0};
        drive_load(0, -1, -1, 0);
        exp_v = model_bits(10);
        n_cmp++;
        if (timed_out || obs_q.size() != 10 || n_rise != 1) begin
            n_bad++;
            $display("FAIL basic_shift_en: got %0d cycles in %0d runs (timeout %0b) want 10 in 1",
                     obs_q.size(), n_rise, timed_out);
        end
        n_cmp++;
        if (pack_obs() !== exp_v) begin
            n_bad++;
            $display("FAIL basic_sequence: got %h want %h", pack_obs(), exp_v);
        end
        n_cmp++;
        if (done[0] !== 1'b1 || bc0 !== 4'd10 || se[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done: got done=%b count=%0d shift_en=%b want 1/10/0",
                     done[0], bc0, se[0]);
        end
        n_cmp++;
        if (n_ready != 1 || cnt_err != 0) begin
            n_bad++;
            $display("FAIL basic_ready_count: got ready=%0d count_err=%0d want 1/0", n_ready, cnt_err);
        end
`ifdef CCFF_LOADER_CRC_EN
        n_cmp++;
        if (crc0 !== model_crc(exp_v, 10)) begin
            n_bad++;
            $display("FAIL basic_crc: got %h want %h", crc0, model_crc(exp_v, 10));
        end
        @(negedge prog_clk);
        n_cmp++;
        if (crc0 !== model_crc(exp_v, 10) || done[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL crc_stable: got %h want %h", crc0, model_crc(exp_v, 10));
        end
`endif
    endtask

    task automatic test_gap(input logic [31:0] w0, input logic [31:0] w1,
                            input int g0, input int g1, input string tag);
        logic [63:0] exp_v;
        words_q = '{w0, w1};
        gaps_q  = '{g0, g1};
        drive_load(1, -1, -1, 0);
        exp_v = model_bits(40);
        n_cmp++;
        if (timed_out || obs_q.size() != 40 || n_rise != 2) begin
            n_bad++;
            $display("FAIL %s_shift_en: got %0d cycles in %0d runs (timeout %0b) want 40 in 2",
                     tag, obs_q.size(), n_rise, timed_out);
        end
        n_cmp++;
        if (pack_obs() !== exp_v) begin
            n_bad++;
            $display("FAIL %s_sequence: got %h want %h", tag, pack_obs(), exp_v);
        end
        // Each accepted word costs one non-shifting LOAD cycle plus its gap.
        n_cmp++;
        if (n_idle_busy != 2 + g0 + g1 || gap_err != 0) begin
            n_bad++;
            $display("FAIL %s_gap: got idle=%0d head_changes=%0d want %0d/0",
                     tag, n_idle_busy, gap_err, 2 + g0 + g1);
        end
        n_cmp++;
        if (done[1] !== 1'b1 || bc1 !== 6'd40 || cnt_err != 0) begin
            n_bad++;
            $display("FAIL %s_done: got done=%b count=%0d count_err=%0d want 1/40/0",
                     tag, done[1], bc1, cnt_err);
        end
`ifdef CCFF_LOADER_CRC_EN
        n_cmp++;
        if (crc1 !== model_crc(exp_v, 40)) begin
            n_bad++;
            $display("FAIL %s_crc: got %h want %h", tag, crc1, model_crc(exp_v, 40));
        end
`endif
    endtask

    task automatic test_start_ignored();
        logic [63:0] exp_v;
        int          at;
        at      = int'($urandom_range(1, 9));
        words_q = '{$urandom};
        gaps_q  = '{int'($urandom_range(0, 2))};
        // Extra start pulses: one mid-shift, one in the final shift cycle.
        drive_load(0, at, 10, 0);
        exp_v = model_bits(10);
        n_cmp++;
        if (timed_out || mono_err != 0 || cnt_err != 0 || obs_q.size() != 10) begin
            n_bad++;
            $display("FAIL start_ignored: got shifts=%0d mono_err=%0d count_err=%0d timeout=%0b want 10/0/0/0 (start at %0d)",
                     obs_q.size(), mono_err, cnt_err, timed_out, at);
        end
        n_cmp++;
        if (pack_obs() !== exp_v || done[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ignored_seq: got %h done=%b want %h done=1", pack_obs(), done[0], exp_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp_v;
        words_q = '{$urandom};
        gaps_q  = '{0};
        drive_load(0, -1, -1, 4);
        #2 rst_n[0] = 1'b0;
        #1;
        n_cmp++;
        if ({ready[0], head[0], se[0], busy[0], done[0], bc0} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %b want 0",
                     {ready[0], head[0], se[0], busy[0], done[0], bc0});
        end
        @(negedge prog_clk);
        rst_n[0] = 1'b1;
        @(negedge prog_clk);
        words_q = '{32'h0000_02B5};
        drive_load(0, -1, -1, 0);
        exp_v = model_bits(10);
        n_cmp++;
        if (timed_out || pack_obs() !== exp_v || obs_q.size() != 10 || done[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_reload: got %h (%0d bits, done=%b) want %h (10 bits, done=1)",
                     pack_obs(), obs_q.size(), done[0], exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_v;
        words_q = '{32'h0000_03FF};
        gaps_q  = '{0};
        drive_load(0, -1, -1, 0);
        exp_v = model_bits(10);
        n_cmp++;
        if (first_done !== 1'b0 || first_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done_drop: got done=%b busy=%b after start want 0/1", first_done, first_busy);
        end
        n_cmp++;
        if (timed_out || pack_obs() !== exp_v || obs_q.size() != 10 || bc0 !== 4'd10) begin
            n_bad++;
            $display("FAIL b2b_sequence: got %h (%0d bits, count=%0d) want %h (10 bits, count=10)",
                     pack_obs(), obs_q.size(), bc0, exp_v);
        end
`ifdef CCFF_LOADER_CRC_EN
        n_cmp++;
        if (crc0 !== model_crc(exp_v, 10)) begin
            n_bad++;
            $display("FAIL b2b_crc: got %h want %h", crc0, model_crc(exp_v, 10));
        end
`endif
    endtask

    initial begin
        wdata[0] = '0;
        wdata[1] = '0;
        test_reset();
        test_basic();
        test_gap(32'hFFFF_FFFF, 32'h0000_00A5, 0, 3, "gap");
        for (int it = 0; it < 3; it++)
            test_gap($urandom, $urandom, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 4)), "random");
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
